// File: rtl/vend_stock_ctrl.sv
// vend_stock_ctrl: per-slot inventory and dispense sequencer for vending_machine.
//
// Keeps one saturating stock counter per slot and publishes item_available from it.
// A valid front-panel selection is latched. The pdt pulse then decrements that slot
// and runs the slot's release motor for MOTOR_CYCLES clocks. Maintenance restock
// requests are serialised against customer dispenses, and a dispense always wins.
//
// Optional feature macro: STOCK_LOW_WARN_EN.
//   Defined     : stock_low[i] is registered and is 1 while 1 <= stock[i] <= 2. Each
//                 rise of stock_low[i] prints a warning in simulation.
//   Not defined : stock_low is tied to 0.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   item_sel       in   one-hot front-panel selection
//   cnl            in   customer cancel
//   pdt            in   product-release pulse
//   restock_req    in   restock request, held until restock_ack
//   restock_idx    in   slot to restock
//   restock_qty    in   units to add
//   restock_ack    out  1-cycle pulse: restock applied
//   item_available out  bit i = stock[i] != 0
//   motor_en       out  one-hot release motor drive
//   busy           out  high while dispensing
//   dispense_err   out  1-cycle pulse on an invalid pdt
//   stock_low      out  low-stock flags (see macro above)

module vend_stock_ctrl #(
    parameter int unsigned NUM_ITEMS    = 4,
    parameter int unsigned STOCK_W      = 4,
    parameter int unsigned MAX_STOCK    = 15,
    parameter int unsigned MOTOR_CYCLES = 4,
    localparam int unsigned IdxW        = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
    localparam int unsigned CntW        = $clog2(MOTOR_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_ITEMS-1:0] item_sel,
    input  logic                 cnl,
    input  logic                 pdt,
    input  logic                 restock_req,
    input  logic [IdxW-1:0]      restock_idx,
    input  logic [STOCK_W-1:0]   restock_qty,
    output logic                 restock_ack,
    output logic [NUM_ITEMS-1:0] item_available,
    output logic [NUM_ITEMS-1:0] motor_en,
    output logic                 busy,
    output logic                 dispense_err,
    output logic [NUM_ITEMS-1:0] stock_low
);

    typedef enum logic [1:0] {StIdle, StArmed, StDispense} state_e;

    state_e               state_q;
    logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
    logic [IdxW-1:0]      sel_idx_q;
    logic [CntW-1:0]      motor_cnt_q;

    logic [IdxW-1:0]      sel_idx;
    logic                 sel_valid;
    logic                 dec_en;
    logic                 restock_en;
    logic [STOCK_W:0]     restock_sum;
    logic [STOCK_W-1:0]   restock_val;
    logic [NUM_ITEMS-1:0] avail_d;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_sel[i]) sel_idx = IdxW'(i);
        end
        sel_valid = $onehot(item_sel) && item_available[sel_idx];

        dec_en = (state_q == StArmed) && pdt && (stock_q[sel_idx_q] != '0);
        // While ack is high the requester has not yet dropped req; do not apply twice.
        restock_en = restock_req && !restock_ack && !dec_en;

        restock_sum = {1'b0, stock_q[restock_idx]} + {1'b0, restock_qty};
        if (restock_sum > (STOCK_W + 1)'(MAX_STOCK)) restock_val = STOCK_W'(MAX_STOCK);
        else                                          restock_val = restock_sum[STOCK_W-1:0];

        // Out-of-range restock_idx matches no slot, so it is acked with no change.
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (dec_en && (sel_idx_q == IdxW'(i)))          stock_d[i] = stock_q[i] - 1'b1;
            if (restock_en && (restock_idx == IdxW'(i)))    stock_d[i] = restock_val;
            avail_d[i] = (stock_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            sel_idx_q      <= '0;
            motor_cnt_q    <= '0;
            restock_ack    <= 1'b0;
            item_available <= '0;
            motor_en       <= '0;
            busy           <= 1'b0;
            dispense_err   <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= '0;
        end else begin
            stock_q        <= stock_d;
            item_available <= avail_d;
            restock_ack    <= restock_en;
            dispense_err   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pdt) dispense_err <= 1'b1;
                    if (sel_valid) begin
                        sel_idx_q <= sel_idx;
                        state_q   <= StArmed;
                    end
                end
                StArmed: begin
                    if (pdt) begin
                        if (dec_en) begin
                            motor_cnt_q <= CntW'(MOTOR_CYCLES);
                            motor_en    <= NUM_ITEMS'(1) << sel_idx_q;
                            busy        <= 1'b1;
                            state_q     <= StDispense;
                        end else begin
                            // Empty slot: refuse, never wrap below zero.
                            dispense_err <= 1'b1;
                            state_q      <= StIdle;
                        end
                    end else if (cnl) begin
                        state_q <= StIdle;
                    end else if (sel_valid) begin
                        sel_idx_q <= sel_idx;
                    end
                end
                StDispense: begin
                    if (pdt) dispense_err <= 1'b1;
                    if (motor_cnt_q == CntW'(1)) begin
                        motor_en <= '0;
                        busy     <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        motor_cnt_q <= motor_cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef STOCK_LOW_WARN_EN
    logic [NUM_ITEMS-1:0] stock_low_d;

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_low_d[i] = (stock_d[i] >= STOCK_W'(1)) && (stock_d[i] <= STOCK_W'(2));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stock_low <= '0;
        else      stock_low <= stock_low_d;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (stock_low_d[i] && !stock_low[i]) $display("[WARNING] Slot %0d stock low", i);
            end
        end
    end
`endif
`else
    assign stock_low = '0;
`endif

endmodule

// File: tb/tb_vend_stock_ctrl.sv
module tb_vend_stock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] item_sel;
    logic       cnl;
    logic       pdt;
    logic       restock_req;
    logic [1:0] restock_idx;
    logic [3:0] restock_qty;
    logic       restock_ack;
    logic [3:0] item_available;
    logic [3:0] motor_en;
    logic       busy;
    logic       dispense_err;
    logic [3:0] stock_low;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    vend_stock_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .item_sel       (item_sel),
        .cnl            (cnl),
        .pdt            (pdt),
        .restock_req    (restock_req),
        .restock_idx    (restock_idx),
        .restock_qty    (restock_qty),
        .restock_ack    (restock_ack),
        .item_available (item_available),
        .motor_en       (motor_en),
        .busy           (busy),
        .dispense_err   (dispense_err),
        .stock_low      (stock_low)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        item_sel = '0; cnl = 1'b0; pdt = 1'b0;
        restock_req = 1'b0; restock_idx = '0; restock_qty = '0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic restock_apply(input logic [1:0] idx, input logic [3:0] qty);
        restock_req = 1'b1; restock_idx = idx; restock_qty = qty;
        step();
        restock_req = 1'b0;
        step();
    endtask

    // Select, pulse pdt, then wait out the four motor cycles; ends back in idle.
    task automatic dispense_seq(input int idx);
        item_sel = 4'b0001 << idx;
        step();
        item_sel = '0;
        pdt = 1'b1;
        step();
        pdt = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({restock_ack, item_available, motor_en, busy, dispense_err, stock_low} !== 15'b0)
            $display("FAIL reset_outputs: got %b want all zero",
                     {restock_ack, item_available, motor_en, busy, dispense_err, stock_low});
        else passes++;
        // Reset asserted in the middle of a dispense.
        restock_apply(2'd3, 4'd2);
        item_sel = 4'b1000;
        step();
        item_sel = '0;
        pdt = 1'b1;
        step();
        pdt = 1'b0;
        step();
        checks++;
        if (motor_en !== 4'b1000) $display("FAIL t1_motor_before: got %b want 1000", motor_en);
        else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({motor_en, item_available, busy} !== 9'b0)
            $display("FAIL t1_async_clear: got motor=%b avail=%b busy=%b want 0",
                     motor_en, item_available, busy);
        else passes++;
        #2 rst = 1'b1;
        step();
        step();
        checks++;
        if (item_available !== 4'b0000)
            $display("FAIL t1_stock_cleared: got %b want 0000", item_available);
        else passes++;
    endtask

    task automatic test_restock();
        do_reset();
        restock_req = 1'b1; restock_idx = 2'd2; restock_qty = 4'd5;
        step();
        restock_req = 1'b0;
        checks++;
        if (restock_ack !== 1'b1 || item_available !== 4'b0100)
            $display("FAIL t2_first_ack: got ack=%b avail=%b want 1/0100", restock_ack, item_available);
        else passes++;
        step();
        checks++;
        if (restock_ack !== 1'b0) $display("FAIL t2_ack_pulse: got %b want 0", restock_ack);
        else passes++;
        restock_req = 1'b1; restock_qty = 4'd14;
        step();
        restock_req = 1'b0;
        checks++;
        if (restock_ack !== 1'b1) $display("FAIL t2_second_ack: got %b want 1", restock_ack);
        else passes++;
        step();
        // Saturated at 15: fourteen dispenses leave the slot available, the fifteenth empties it.
        for (int n = 0; n < 14; n++) dispense_seq(2);
        checks++;
        if (item_available !== 4'b0100)
            $display("FAIL t2_after_14: got %b want 0100", item_available);
        else passes++;
        dispense_seq(2);
        checks++;
        if (item_available !== 4'b0000)
            $display("FAIL t2_after_15: got %b want 0000", item_available);
        else passes++;
    endtask

    task automatic test_dispense();
        do_reset();
        restock_apply(2'd0, 4'd1);
        item_sel = 4'b0001;
        step();
        item_sel = '0;
        pdt = 1'b1;
        step();
        pdt = 1'b0;
        checks++;
        if (motor_en !== 4'b0001 || busy !== 1'b1 || item_available !== 4'b0000)
            $display("FAIL t3_start: got motor=%b busy=%b avail=%b want 0001/1/0000",
                     motor_en, busy, item_available);
        else passes++;
        for (int c = 2; c <= 4; c++) begin
            step();
            checks++;
            if (motor_en !== 4'b0001) $display("FAIL t3_motor_cycle%0d: got %b want 0001", c, motor_en);
            else passes++;
        end
        step();
        checks++;
        if (motor_en !== 4'b0000 || busy !== 1'b0)
            $display("FAIL t3_end: got motor=%b busy=%b want 0000/0", motor_en, busy);
        else passes++;
    endtask

    task automatic test_invalid();
        do_reset();
        pdt = 1'b1;
        step();
        pdt = 1'b0;
        checks++;
        if (dispense_err !== 1'b1 || motor_en !== 4'b0000)
            $display("FAIL t4_pdt_idle: got err=%b motor=%b want 1/0000", dispense_err, motor_en);
        else passes++;
        step();
        checks++;
        if (dispense_err !== 1'b0) $display("FAIL t4_err_pulse: got %b want 0", dispense_err);
        else passes++;
        restock_apply(2'd0, 4'd2);
        restock_apply(2'd1, 4'd2);
        // Multi-hot, then empty slot: neither arms, so pdt still reports an error.
        item_sel = 4'b0011;
        step();
        item_sel = '0;
        pdt = 1'b1;
        step();
        pdt = 1'b0;
        checks++;
        if (dispense_err !== 1'b1 || motor_en !== 4'b0000)
            $display("FAIL t4_multihot: got err=%b motor=%b want 1/0000", dispense_err, motor_en);
        else passes++;
        item_sel = 4'b0100;
        step();
        item_sel = '0;
        pdt = 1'b1;
        step();
        pdt = 1'b0;
        checks++;
        if (dispense_err !== 1'b1 || motor_en !== 4'b0000)
            $display("FAIL t4_empty_slot: got err=%b motor=%b want 1/0000", dispense_err, motor_en);
        else passes++;
        // Cancel returns to idle.
        item_sel = 4'b0001;
        step();
        item_sel = '0;
        cnl = 1'b1;
        step();
        cnl = 1'b0;
        pdt = 1'b1;
        step();
        pdt = 1'b0;
        checks++;
        if (dispense_err !== 1'b1 || motor_en !== 4'b0000)
            $display("FAIL t4_cancel: got err=%b motor=%b want 1/0000", dispense_err, motor_en);
        else passes++;
        // Re-latch while armed: the last valid selection is dispensed.
        item_sel = 4'b0001;
        step();
        item_sel = 4'b0010;
        step();
        item_sel = '0;
        pdt = 1'b1;
        step();
        checks++;
        if (motor_en !== 4'b0010) $display("FAIL t4_relatch: got %b want 0010", motor_en);
        else passes++;
        // pdt held into DISPENSE is an error and does not decrement again.
        step();
        pdt = 1'b0;
        checks++;
        if (dispense_err !== 1'b1 || item_available !== 4'b0011)
            $display("FAIL t4_pdt_dispense: got err=%b avail=%b want 1/0011", dispense_err, item_available);
        else passes++;
        repeat (4) step();
    endtask

    task automatic test_collision();
        int waited;
        do_reset();
        restock_apply(2'd1, 4'd3);
        item_sel = 4'b0010;
        step();
        item_sel = '0;
        pdt = 1'b1;
        restock_req = 1'b1; restock_idx = 2'd1; restock_qty = 4'd2;
        step();
        pdt = 1'b0;
        checks++;
        if (restock_ack !== 1'b0 || motor_en !== 4'b0010)
            $display("FAIL t5_dec_first: got ack=%b motor=%b want 0/0010", restock_ack, motor_en);
        else passes++;
        step();
        restock_req = 1'b0;
        checks++;
        if (restock_ack !== 1'b1) $display("FAIL t5_late_ack: got %b want 1", restock_ack);
        else passes++;
        waited = 0;
        while (busy === 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL t5_wait_idle: got busy=%b want 0 within 20 cycles", busy);
        else passes++;
        // 3 - 1 + 2 = 4 units left in slot 1.
        for (int n = 0; n < 3; n++) dispense_seq(1);
        checks++;
        if (item_available !== 4'b0010)
            $display("FAIL t5_after_3: got %b want 0010", item_available);
        else passes++;
        dispense_seq(1);
        checks++;
        if (item_available !== 4'b0000)
            $display("FAIL t5_after_4: got %b want 0000", item_available);
        else passes++;
    endtask

    task automatic test_stock_low();
        do_reset();
        restock_apply(2'd3, 4'd3);
        checks++;
        if (stock_low !== 4'b0000) $display("FAIL t6_low_at3: got %b want 0000", stock_low);
        else passes++;
        dispense_seq(3);
`ifdef STOCK_LOW_WARN_EN
        checks++;
        if (stock_low !== 4'b1000) $display("FAIL t6_low_at2: got %b want 1000", stock_low);
        else passes++;
`else
        checks++;
        if (stock_low !== 4'b0000) $display("FAIL t6_low_disabled: got %b want 0000", stock_low);
        else passes++;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_restock();
        test_dispense();
        test_invalid();
        test_collision();
        test_stock_low();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
